// File: rtl/ddr_burst_reader.sv
// Avalon-MM burst-read initiator: fetches a block of 64-bit DDR words and streams them out in order.
// Optional abort support is compiled in with `define DDR_BURST_READER_ABORT_EN.
module ddr_burst_reader #(
   parameter int FIFO_AW   = 7,
   parameter int MAX_BURST = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [28:0] base_addr,
   input  logic [23:0] length,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [28:0] ram_address,
   output logic [7:0]  ram_burstcount,
   output logic        ram_read,
   input  logic        ram_waitrequest,
   input  logic [63:0] ram_readdata,
   input  logic        ram_readdatavalid
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = FIFO_AW + 1;

   typedef enum logic [2:0] {
      IDLE, ARB, REQ, DRAIN
`ifdef DDR_BURST_READER_ABORT_EN
      , ABORT
`endif
   } state_t;

   state_t             state;
   logic [28:0]        addr;
   logic [23:0]        remaining;
   logic [CW-1:0]      outstanding;
   logic [CW-1:0]      mem_count;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [63:0]        mem [DEPTH];

   logic [7:0]         blen;
   logic [CW-1:0]      free;
   logic [CW-1:0]      out_inc;
   logic [CW-1:0]      out_dec;
   logic               accept;
   logic               pop;
   logic               load_out;
   logic               mem_rd;
   logic               bypass;
   logic               push;
   logic               flush;
   logic               go_abort;

   assign blen    = (remaining < 24'(MAX_BURST)) ? remaining[7:0] : 8'(MAX_BURST);
   // Credits: every word already issued or buffered (including the output register) is reserved.
   assign free    = CW'(DEPTH) - mem_count - CW'(out_valid) - outstanding;
   assign accept  = (state == REQ) && ram_read && !ram_waitrequest;
   assign out_inc = accept ? CW'(ram_burstcount) : '0;
   assign out_dec = CW'(ram_readdatavalid);

   assign pop      = out_valid && out_ready;
   assign load_out = !out_valid || pop;
   assign mem_rd   = load_out && (mem_count != '0);
   assign bypass   = load_out && (mem_count == '0) && ram_readdatavalid;
   assign push     = ram_readdatavalid && !bypass && !flush;

`ifdef DDR_BURST_READER_ABORT_EN
   localparam state_t STOP_STATE = ABORT;
   assign go_abort = abort && ((state == ARB) || (state == DRAIN) || accept);
   assign flush    = go_abort || (state == ABORT);
`else
   localparam state_t STOP_STATE = IDLE;
   logic unused_ok;
   assign unused_ok = abort;
   assign go_abort  = 1'b0;
   assign flush     = 1'b0;
`endif

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         ram_read       <= 1'b0;
         ram_address    <= '0;
         ram_burstcount <= '0;
         addr           <= '0;
         remaining      <= '0;
         outstanding    <= '0;
      end else begin
         done        <= 1'b0;
         outstanding <= outstanding + out_inc - out_dec;
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= base_addr;
                  remaining <= length;
                  if (length == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy  <= 1'b1;
                     state <= ARB;
                  end
               end
            end
            ARB: begin
               if (go_abort) begin
                  state <= STOP_STATE;
               end else if (32'(free) >= 32'(blen)) begin
                  ram_address    <= addr;
                  ram_burstcount <= blen;
                  ram_read       <= 1'b1;
                  state          <= REQ;
               end
            end
            REQ: begin
               if (accept) begin
                  ram_read  <= 1'b0;
                  addr      <= addr + 29'(ram_burstcount);
                  remaining <= remaining - 24'(ram_burstcount);
                  if (go_abort)
                     state <= STOP_STATE;
                  else if (remaining != 24'(ram_burstcount))
                     state <= ARB;
                  else
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               // Finish in the same edge as the last handshake so done lands one cycle after it.
               if (go_abort) begin
                  state <= STOP_STATE;
               end else if (outstanding == '0 && mem_count == '0 && (!out_valid || out_ready)) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
`ifdef DDR_BURST_READER_ABORT_EN
            ABORT: begin
               if (outstanding == '0) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   // Show-ahead FIFO: memory plus an output register that can be loaded straight from the bus.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         mem_count <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         mem_count <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
      end else begin
         if (mem_rd) begin
            out_data  <= mem[rd_ptr];
            out_valid <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
         end else if (bypass) begin
            out_data  <= ram_readdata;
            out_valid <= 1'b1;
         end else if (load_out) begin
            out_valid <= 1'b0;
         end
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         mem_count <= mem_count + CW'(push) - CW'(mem_rd);
      end
   end

   // NOTE: the storage array has no reset; occupancy is tracked by mem_count, so stale contents are never read.
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= ram_readdata;
   end

endmodule

// File: tb/tb_ddr_burst_reader.sv
// Self-checking bench for ddr_burst_reader: DDR slave model, stream sink and block-level reference model.
`timescale 1ns/1ps
module tb_ddr_burst_reader;
   localparam int MAXB  = 64;
   localparam int DEPTH = 128;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [28:0] base_addr = '0;
   logic [23:0] length = '0;
   logic        out_ready = 1'b0;
   logic        ram_waitrequest = 1'b0;
   logic        ram_readdatavalid = 1'b0;
   logic [63:0] ram_readdata = '0;
   logic        busy, done, out_valid, ram_read;
   logic [63:0] out_data;
   logic [28:0] ram_address;
   logic [7:0]  ram_burstcount;

   ddr_burst_reader dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .abort(abort), .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .ram_address(ram_address), .ram_burstcount(ram_burstcount),
      .ram_read(ram_read), .ram_waitrequest(ram_waitrequest), .ram_readdata(ram_readdata),
      .ram_readdatavalid(ram_readdatavalid)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] data_of(input logic [28:0] a);
      return {a, 3'b010, a ^ 29'h0ABCDEF1, 3'b101};
   endfunction

   typedef struct {
      logic [28:0] addr;
      logic [7:0]  bc;
   } burst_t;

   // Reference model state: expected requests and words, slave's queued return data.
   burst_t      exp_bursts[$];
   logic [63:0] exp_words[$];
   logic [28:0] pending[$];
   int issued = 0, popped = 0, n_acc = 0, rd_seen = 0;
   int done_cnt = 0, done_cyc = 0, hs_cyc = 0, start_cyc = 0, done0 = 0;
   logic [7:0] last_bc = '0;
   int wait_mode = 0, ready_mode = 0, rdv_mode = 0;
   bit rdv_hold = 1'b0, abort_phase = 1'b0;

   // Monitor-private state
   bit          hold_seen = 1'b0, prev_stall = 1'b0, wr, rd;
   int          stall_cnt = 0;
   logic [28:0] hold_addr;
   logic [7:0]  hold_bc;
   logic [63:0] prev_data;
   burst_t      mon_b;

   // Slave and sink act on the falling edge; their outputs take effect at the next rising edge.
   initial begin
      forever begin
         @(negedge clock);
         if (reset) begin
            hold_seen = 1'b0; prev_stall = 1'b0; stall_cnt = 0;
            ram_waitrequest = 1'b0; ram_readdatavalid = 1'b0; out_ready = 1'b0;
         end else begin
            check("credit", 64'(issued - popped <= DEPTH), 64'd1);
            if (!rdv_hold && pending.size() > 0 && (rdv_mode == 0 || $urandom_range(3) != 0)) begin
               ram_readdatavalid = 1'b1;
               ram_readdata      = data_of(pending.pop_front());
            end else begin
               ram_readdatavalid = 1'b0;
               ram_readdata      = {$urandom, $urandom};
            end
            wr = 1'b0;
            if (ram_read) begin
               rd_seen++;
               if (hold_seen) begin
                  check("req_addr_stable", 64'(ram_address), 64'(hold_addr));
                  check("req_bc_stable", 64'(ram_burstcount), 64'(hold_bc));
               end else begin
                  hold_seen = 1'b1; hold_addr = ram_address; hold_bc = ram_burstcount; stall_cnt = 0;
               end
               case (wait_mode)
                  1: wr = ($urandom_range(3) == 0);
                  2: wr = (stall_cnt < 5);
                  3: wr = 1'b1;
                  default: wr = 1'b0;
               endcase
               stall_cnt++;
               if (!wr) begin
                  hold_seen = 1'b0;
                  n_acc++;
                  last_bc = ram_burstcount;
                  issued += int'(ram_burstcount);
                  if (exp_bursts.size() == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_req: addr %0h bc %0d, none expected", ram_address, ram_burstcount);
                  end else begin
                     mon_b = exp_bursts.pop_front();
                     check("req_addr", 64'(ram_address), 64'(mon_b.addr));
                     check("req_bc", 64'(ram_burstcount), 64'(mon_b.bc));
                  end
                  for (int i = 0; i < int'(ram_burstcount); i++)
                     pending.push_back(ram_address + 29'(i));
               end
            end else if (wait_mode == 1) begin
               wr = 1'($urandom_range(1));
            end
            ram_waitrequest = wr;

            if (prev_stall && !abort_phase) begin
               check("hold_valid", 64'(out_valid), 64'd1);
               check("hold_data", out_data, prev_data);
            end
            case (ready_mode)
               1: rd = 1'($urandom_range(1));
               2: rd = 1'b0;
               default: rd = 1'b1;
            endcase
            if (out_valid && rd) begin
               popped++;
               hs_cyc = cyc;
               if (exp_words.size() == 0) begin
                  total++; bad++;
                  $display("FAIL extra_word: got %0h with nothing expected", out_data);
               end else begin
                  check("word", out_data, exp_words.pop_front());
               end
            end
            prev_stall = out_valid && !rd;
            prev_data  = out_data;
            out_ready  = rd;
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
         end
      end
   end

   // Expected behaviour from the block's rules: MAX_BURST-sized chunks, words at base+i mod 2^29.
   task automatic plan(input logic [28:0] base, input int len);
      logic [28:0] a = base;
      int r = len;
      burst_t b;
      while (r > 0) begin
         b.addr = a;
         b.bc   = 8'((r < MAXB) ? r : MAXB);
         exp_bursts.push_back(b);
         a += 29'(b.bc);
         r -= int'(b.bc);
      end
      for (int i = 0; i < len; i++)
         exp_words.push_back(data_of(base + 29'(i)));
   endtask

   task automatic launch(input logic [28:0] base, input int len);
      plan(base, len);
      @(negedge clock);
      done0 = done_cnt;
      start = 1'b1; base_addr = base; length = 24'(len);
      start_cyc = cyc;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic finish_block(input string tag, input int budget);
      int c = 0;
      while (done_cnt == done0 && c < budget) begin
         @(negedge clock);
         c++;
      end
      check({tag, ":done_seen"}, 64'(done_cnt != done0), 64'd1);
      repeat (3) @(negedge clock);
      check({tag, ":done_once"}, 64'(done_cnt - done0), 64'd1);
      check({tag, ":done_after_hs"}, 64'(done_cyc - hs_cyc), 64'd1);
      check({tag, ":busy_low"}, 64'(busy), 64'd0);
      check({tag, ":words_left"}, 64'(exp_words.size()), 64'd0);
      check({tag, ":bursts_left"}, 64'(exp_bursts.size()), 64'd0);
   endtask

   typedef struct {
      logic [28:0] base;
      int len;
      int wmode;
      int rmode;
      int exp_nb;
      int exp_lbc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n0, r0, i0, p0, c, nb;
      bit saw_valid;
      logic [28:0] rb;
      int rl;

      vecs[0] = '{29'h1000,     1,   0, 0, 1, 1};
      vecs[1] = '{29'h100,      200, 0, 0, 4, 8};
      vecs[2] = '{29'h2000,     130, 2, 0, 3, 2};
      vecs[3] = '{29'h1FFFFFF8, 70,  0, 1, 2, 6};
      vecs[4] = '{29'h40,       64,  1, 1, 1, 64};
      vecs[5] = '{29'h300,      129, 1, 0, 3, 1};

      repeat (3) @(negedge clock);
      check("rst:busy", 64'(busy), 64'd0);
      check("rst:ram_read", 64'(ram_read), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check("rst:done", 64'(done), 64'd0);
      check("rst:out_valid", 64'(out_valid), 64'd0);
      check("rst:ram_address", 64'(ram_address), 64'd0);
      check("rst:ram_burstcount", 64'(ram_burstcount), 64'd0);
      check("rst:out_data", out_data, 64'd0);

      // Table of block reads with expected request count and final burst size
      for (int v = 0; v < 6; v++) begin
         wait_mode = vecs[v].wmode; ready_mode = vecs[v].rmode; rdv_mode = 0;
         n0 = n_acc;
         launch(vecs[v].base, vecs[v].len);
         finish_block($sformatf("vec%0d", v), 4000);
         check($sformatf("vec%0d:bursts", v), 64'(n_acc - n0), 64'(vecs[v].exp_nb));
         check($sformatf("vec%0d:last_bc", v), 64'(last_bc), 64'(vecs[v].exp_lbc));
      end
      wait_mode = 0; ready_mode = 0; rdv_mode = 0;

      // Zero length: done next cycle, no read
      r0 = rd_seen;
      launch(29'h777, 0);
      check("len0:done", 64'(done), 64'd1);
      check("len0:busy", 64'(busy), 64'd0);
      @(negedge clock);
      check("len0:done_pulse", 64'(done), 64'd0);
      repeat (3) @(negedge clock);
      check("len0:no_read", 64'(rd_seen - r0), 64'd0);

      // Start latency and full-rate streaming
      launch(29'h8000, 64);
      check("lat:busy", 64'(busy), 64'd1);
      check("lat:no_read_yet", 64'(ram_read), 64'd0);
      @(negedge clock);
      check("lat:read", 64'(ram_read), 64'd1);
      check("lat:addr", 64'(ram_address), 64'h8000);
      finish_block("lat", 500);
      check("lat:total_cycles", 64'(done_cyc - start_cyc), 64'd68);

      // Start while busy is ignored, with 5-cycle stalls on every request
      wait_mode = 2;
      launch(29'h100, 200);
      repeat (10) @(negedge clock);
      start = 1'b1; base_addr = 29'h5000; length = 24'd7;
      @(negedge clock);
      start = 1'b0;
      finish_block("busy_start", 4000);
      wait_mode = 0;

      // Long backpressure: at most 128 words in flight, reads stall
      ready_mode = 2;
      i0 = issued;
      launch(29'h20000, 512);
      repeat (1000) @(negedge clock);
      check("bp:issued", 64'(issued - i0), 64'd128);
      ready_mode = 0;
      finish_block("bp", 4000);

`ifdef DDR_BURST_READER_ABORT_EN
      ready_mode = 2; rdv_hold = 1'b1;
      i0 = issued; p0 = popped;
      launch(29'h40000, 512);
      c = 0;
      while (issued - i0 < 128 && c < 200) begin
         @(negedge clock);
         c++;
      end
      check("abort:issued", 64'(issued - i0), 64'd128);
      rdv_hold = 1'b0;
      repeat (10) @(negedge clock);
      rdv_hold = 1'b1;
      @(negedge clock);
      check("abort:fifo_has_data", 64'(out_valid), 64'd1);
      abort_phase = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check("abort:valid_cleared", 64'(out_valid), 64'd0);
      rdv_hold = 1'b0;
      saw_valid = 1'b0;
      c = 0;
      while (done_cnt == done0 && c < 500) begin
         @(negedge clock);
         if (out_valid) saw_valid = 1'b1;
         c++;
      end
      check("abort:done_seen", 64'(done_cnt - done0), 64'd1);
      check("abort:no_output", 64'(saw_valid), 64'd0);
      repeat (3) @(negedge clock);
      check("abort:busy_low", 64'(busy), 64'd0);
      check("abort:no_new_req", 64'(issued - i0), 64'd128);
      check("abort:no_pop", 64'(popped - p0), 64'd0);
      check("abort:absorbed", 64'(pending.size()), 64'd0);
      exp_bursts.delete(); exp_words.delete();
      issued = 0; popped = 0;
      abort_phase = 1'b0; ready_mode = 0;
`else
      launch(29'h60000, 300);
      repeat (40) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      finish_block("abort_ignored", 4000);
`endif

      // Asynchronous reset while a request is stalled
      wait_mode = 3;
      launch(29'h1234, 100);
      c = 0;
      while (!ram_read && c < 20) begin
         @(negedge clock);
         c++;
      end
      check("arst:req_seen", 64'(ram_read), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("arst:busy", 64'(busy), 64'd0);
      check("arst:ram_read", 64'(ram_read), 64'd0);
      check("arst:ram_address", 64'(ram_address), 64'd0);
      check("arst:ram_burstcount", 64'(ram_burstcount), 64'd0);
      check("arst:out_valid", 64'(out_valid), 64'd0);
      check("arst:done", 64'(done), 64'd0);
      exp_bursts.delete(); exp_words.delete(); pending.delete();
      issued = 0; popped = 0;
      wait_mode = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      launch(29'h9000, 10);
      finish_block("after_rst", 1000);

      // Randomised blocks against the reference model
      for (int k = 0; k < 8; k++) begin
         rb = 29'($urandom);
         rl = $urandom_range(300, 1);
         wait_mode = $urandom_range(1); ready_mode = $urandom_range(1); rdv_mode = $urandom_range(1);
         nb = (rl + MAXB - 1) / MAXB;
         n0 = n_acc;
         launch(rb, rl);
         finish_block($sformatf("rnd%0d", k), 6000);
         check($sformatf("rnd%0d:bursts", k), 64'(n_acc - n0), 64'(nb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
